sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares one toggle-handshake SDRAM request port (req/ack/we/a/ds/d/q) between NCLI clients, e.g. ROM download, hiscore save/restore and CPU work-RAM writes.
- Clients use a level request held until a one-cycle done pulse.
- The arbiter serialises client requests onto the SDRAM port: one outstanding transaction at a time.
- Client 0 has fixed top priority; the remaining clients are served round-robin.

Parameters:
- NCLI, 3, number of clients (2..8).
- AW, 23, word address width (address bits 23:1).
- DW, 16, data width.
- TIMEOUT, 1023, WAIT cycles before timeout_err is set; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- cli_req  in  NCLI  level request per client; held until the matching cli_done.
- cli_we  in  NCLI  1=write, 0=read.
- cli_a  in  NCLI*AW  packed word addresses; client i at [i*AW +: AW].
- cli_ds  in  NCLI*2  packed byte selects {upper,lower}.
- cli_d  in  NCLI*DW  packed write data.
- hold_low  in  1  when 1, clients 1..NCLI-1 are not granted (used during download).
- cli_done  out  NCLI  one-cycle completion pulse to the granted client.
- cli_q  out  DW  read data; valid while cli_done is high and held until the next read completes.
- port_req  out  1  toggle request to the SDRAM controller.
- port_ack  in  1  toggle acknowledge; the transaction is complete when port_ack == port_req.
- port_we, port_a[AW], port_ds[2], port_d[DW]  out  registered command fields; stable from ISSUE until DONE.
- port_q  in  DW  SDRAM read data; valid when port_ack matches port_req.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- States: SYNC, IDLE, ISSUE, WAIT, DONE.
- Reset values:
  - state=SYNC, cli_done=0, cli_q=0, timeout_err=0, rr_ptr=NCLI-1, port_we=0, port_a=0, port_ds=0, port_d=0.
  - port_req is NOT reset (power-up 0). This keeps the toggle protocol aligned with the controller's handshake state, which is not reset.
  - busy=1 during SYNC.
- SYNC: wait until port_ack == port_req, then go to IDLE. This drains a transaction cut off by a mid-operation reset; that transaction's result is discarded and no cli_done is issued.
- IDLE grant rules:
  - If cli_req[0]=1, grant client 0.
  - Else, unless hold_low=1, grant the first requesting client scanning rr_ptr+1, rr_ptr+2 ... cyclically over 1..NCLI-1.
  - On grant: latch that client's we/a/ds/d into port_* and store the grant index. Update rr_ptr to the grant only if the grant is not 0. Go to ISSUE.
  - With no eligible request, stay in IDLE.
- ISSUE (1 cycle): port_req <= ~port_req; clear the watchdog counter; go to WAIT.
- WAIT:
  - When port_ack == port_req: for a read, cli_q <= port_q (sampled the same cycle); go to DONE.
  - The watchdog counter increments each WAIT cycle. If TIMEOUT != 0 and the counter reaches TIMEOUT, set timeout_err=1 (sticky until reset) and keep waiting. There is no abort.
- DONE (1 cycle): cli_done[grant]=1; go to IDLE.
  - The client drops cli_req on the edge ending DONE, so IDLE never re-grants a completed request.
  - A request still high in IDLE is treated as a new transaction.
- Latency from cli_req rising in IDLE to cli_done is 3 + controller latency (edges: grant, toggle, ack seen, done).
  - Minimum is 4 cycles when the ack arrives on the first WAIT cycle.
- Client cli_a/d/we/ds changes after grant are ignored until the next grant.
- Simultaneous requests from all clients with hold_low=0: the order is 0 (while requesting), then 1, 2, ..., cycling.
- cli_done is never asserted for more than one client in the same cycle.

Decomposition:
- Package sdram_arb_pkg: state enum (SYNC, IDLE, ISSUE, WAIT, DONE), TIMEOUT width constant, a pack/unpack helper function for client fields.
- One sub-module, rr_pick:
  - Combinational round-robin selector.
  - Inputs: request vector, pointer, mask.
  - Outputs: valid, index.
  - Unit-testable on its own.

Test Plan:
- Single write:
  - Stimulus: client 1 requests we=1, a=0x000123, ds=2'b11, d=0xBEEF; ack model toggles 3 cycles after port_req.
  - Response: port_a=0x000123, port_d=0xBEEF; exactly one cli_done[1] pulse, 6 cycles after request.
- Read:
  - Stimulus: client 2 reads a=0x400010; model returns port_q=0x5A5A with the ack.
  - Response: cli_q=0x5A5A while cli_done[2]=1, and cli_q holds afterwards.
- Arbitration:
  - Stimulus: clients 0, 1, 2 request together and each re-requests immediately after done, for 9 grants.
  - Response: client 0 is always served first whenever requesting. With client 0 idle, the sequence is 1, 2, 1, 2.
  - hold_low=1 suppresses clients 1 and 2 entirely.
- Reset mid-WAIT:
  - Stimulus: assert reset for 1 cycle while port_req=1 and port_ack=0; ack arrives 5 cycles later.
  - Response: busy=1 and no cli_done until the ack. Then IDLE; the next request toggles port_req to 0 and completes normally.
- Watchdog:
  - Stimulus: TIMEOUT=8; ack withheld for 20 cycles.
  - Response: timeout_err=1 after 8 WAIT cycles and stays set. The transaction still completes with cli_done when the ack arrives.
- Back-to-back:
  - Stimulus: client 1 holds cli_req high across done.
  - Response: a second transaction starts in the IDLE cycle after DONE, with port_req toggled again.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Watchdog counter width; TIMEOUT must fit below 2**WDOG_W.
  localparam int WDOG_W = 16;

  // Bit offset of client idx within a packed per-client field bus.
  function automatic int field_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// Combinational round-robin selector over clients 1..N-1 (index 0 is never picked).
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic [N-1:0]  i_mask,
  output logic          o_valid,
  output logic [IW-1:0] o_index
);

  always_comb begin
    int w_cand_i;
    logic [IW-1:0] w_cand;
    o_valid  = 1'b0;
    o_index  = '0;
    w_cand_i = 0;
    w_cand   = '0;
    // Scan ptr+1, ptr+2, ... wrapping within 1..N-1; first hit wins.
    for (int k = 1; k < N; k++) begin
      w_cand_i = ((int'(i_ptr) - 1 + k) % (N - 1)) + 1;
      w_cand   = IW'(w_cand_i);
      if (!o_valid && i_req[w_cand] && i_mask[w_cand]) begin
        o_valid = 1'b1;
        o_index = w_cand;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Serialises NCLI level-request clients onto one toggle-handshake SDRAM port.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NCLI    = 3,
  parameter int AW      = 23,
  parameter int DW      = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCLI-1:0]   cli_req,
  input  logic [NCLI-1:0]   cli_we,
  input  logic [NCLI*AW-1:0] cli_a,
  input  logic [NCLI*2-1:0] cli_ds,
  input  logic [NCLI*DW-1:0] cli_d,
  input  logic              hold_low,
  output logic [NCLI-1:0]   cli_done,
  output logic [DW-1:0]     cli_q,
  output logic              port_req,
  input  logic              port_ack,
  output logic              port_we,
  output logic [AW-1:0]     port_a,
  output logic [1:0]        port_ds,
  output logic [DW-1:0]     port_d,
  input  logic [DW-1:0]     port_q,
  output logic              busy,
  output logic              timeout_err
);

  localparam int IW = $clog2(NCLI);

  logic [AW-1:0] w_a  [NCLI];
  logic [1:0]    w_ds [NCLI];
  logic [DW-1:0] w_d  [NCLI];

  for (genvar gi = 0; gi < NCLI; gi++) begin : g_unpack
    assign w_a[gi]  = cli_a[field_lsb(gi, AW) +: AW];
    assign w_ds[gi] = cli_ds[field_lsb(gi, 2) +: 2];
    assign w_d[gi]  = cli_d[field_lsb(gi, DW) +: DW];
  end

  state_t              r_state;
  logic [IW-1:0]       r_grant;
  logic [IW-1:0]       r_rr_ptr;
  logic [WDOG_W-1:0]   r_wdog;
  logic                r_port_req;
  logic                r_we;
  logic [AW-1:0]       r_a;
  logic [1:0]          r_ds;
  logic [DW-1:0]       r_d;
  logic [NCLI-1:0]     r_done;
  logic [DW-1:0]       r_q;
  logic                r_err;

  logic                w_rr_valid;
  logic [IW-1:0]       w_rr_idx;
  logic [NCLI-1:0]     w_mask;
  logic                w_gnt_valid;
  logic [IW-1:0]       w_gnt_idx;
  logic                w_acked;

  assign w_mask      = {NCLI{~hold_low}};
  assign w_gnt_valid = cli_req[0] | w_rr_valid;
  assign w_gnt_idx   = cli_req[0] ? '0 : w_rr_idx;
  assign w_acked     = (port_ack == r_port_req);

  rr_pick #(.N(NCLI), .IW(IW)) u_rr_pick (
    .i_req   (cli_req),
    .i_ptr   (r_rr_ptr),
    .i_mask  (w_mask),
    .o_valid (w_rr_valid),
    .o_index (w_rr_idx)
  );

  // The toggle stays unreset so it tracks the controller's unreset handshake.
  always_ff @(posedge clk) begin
    if (!reset && r_state == ST_ISSUE) r_port_req <= ~r_port_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_SYNC;
      r_grant  <= '0;
      r_rr_ptr <= IW'(NCLI - 1);
      r_wdog   <= '0;
      r_we     <= 1'b0;
      r_a      <= '0;
      r_ds     <= '0;
      r_d      <= '0;
      r_done   <= '0;
      r_q      <= '0;
      r_err    <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_SYNC: if (w_acked) r_state <= ST_IDLE;
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_we    <= cli_we[w_gnt_idx];
            r_a     <= w_a[w_gnt_idx];
            r_ds    <= w_ds[w_gnt_idx];
            r_d     <= w_d[w_gnt_idx];
            r_grant <= w_gnt_idx;
            if (w_gnt_idx != '0) r_rr_ptr <= w_gnt_idx;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_wdog  <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_wdog != '1) r_wdog <= r_wdog + 1'b1;
          // This cycle is WAIT cycle r_wdog+1; flag once it reaches TIMEOUT.
          if (TIMEOUT != 0 && r_wdog >= WDOG_W'(TIMEOUT - 1)) r_err <= 1'b1;
          if (w_acked) begin
            if (!r_we) r_q <= port_q;
            r_done  <= NCLI'(1) << r_grant;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_SYNC;
      endcase
    end
  end

  assign port_req    = r_port_req;
  assign port_we     = r_we;
  assign port_a      = r_a;
  assign port_ds     = r_ds;
  assign port_d      = r_d;
  assign cli_done    = r_done;
  assign cli_q       = r_q;
  assign timeout_err = r_err;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter with a delayed toggle-ack SDRAM model.
module tb_sdram_port_arbiter;

  localparam int NCLI = 3;
  localparam int AW   = 23;
  localparam int DW   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset    = 1'b1;
  logic [NCLI-1:0]   cli_req  = '0;
  logic [NCLI-1:0]   cli_we   = '0;
  logic [NCLI*AW-1:0] cli_a   = '0;
  logic [NCLI*2-1:0] cli_ds   = '0;
  logic [NCLI*DW-1:0] cli_d   = '0;
  logic              hold_low = 1'b0;
  logic [NCLI-1:0]   cli_done;
  logic [DW-1:0]     cli_q;
  logic              port_req;
  logic              port_ack = 1'b0;
  logic              port_we;
  logic [AW-1:0]     port_a;
  logic [1:0]        port_ds;
  logic [DW-1:0]     port_d;
  logic [DW-1:0]     port_q   = '0;
  logic              busy;
  logic              timeout_err;

  sdram_port_arbiter #(.NCLI(NCLI), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .cli_req(cli_req), .cli_we(cli_we), .cli_a(cli_a), .cli_ds(cli_ds), .cli_d(cli_d),
    .hold_low(hold_low), .cli_done(cli_done), .cli_q(cli_q),
    .port_req(port_req), .port_ack(port_ack), .port_we(port_we), .port_a(port_a),
    .port_ds(port_ds), .port_d(port_d), .port_q(port_q),
    .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [2:0]  cli;
    logic        we;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
    logic [15:0] q;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_rr = NCLI - 1;
  logic exp_preq = 1'b0;
  logic [15:0] mem [logic [22:0]];

  int ack_delay = 3;
  bit ack_hold  = 1'b0;
  int ack_cnt   = 0;

  function automatic logic [15:0] rd_model(input logic [22:0] a);
    if (mem.exists(a)) return mem[a];
    return a[15:0] ^ 16'h3C96;
  endfunction

  // SDRAM controller model: answers a pending toggle ack_delay cycles after seeing it.
  always @(posedge clk) begin
    if (port_req != port_ack && !ack_hold) begin
      if (ack_cnt + 1 >= ack_delay) begin
        port_ack <= port_req;
        port_q   <= rd_model(port_a);
        ack_cnt  <= 0;
      end else ack_cnt <= ack_cnt + 1;
    end else ack_cnt <= 0;
  end

  always @(negedge clk) begin
    if (cli_done != '0) begin
      $display("txn: done=%b we=%0d a=%h ds=%b d=%h q=%h", cli_done, port_we, port_a, port_ds, port_d, cli_q);
      n_cmp++;
      if ($countones(cli_done) != 1) begin
        n_err++;
        $display("FAIL onehot_done: got %b, required exactly one bit", cli_done);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic drive(input int i, input logic we, input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
    cli_we[i]            = we;
    cli_a[i*AW +: AW]    = a;
    cli_ds[i*2 +: 2]     = ds;
    cli_d[i*DW +: DW]    = d;
    cli_req[i]           = 1'b1;
    exp_q.push_back({3'(i), we, a, ds, d, we ? 16'h0 : rd_model(a)});
  endtask

  function automatic exp_t pop_exp(input int i, output bit found);
    exp_t e;
    found = 1'b0;
    e = '0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (!found && int'(exp_q[k].cli) == i) begin
        e = exp_q[k];
        exp_q.delete(k);
        found = 1'b1;
        break;
      end
    end
    return e;
  endfunction

  function automatic exp_t observe(input int idx);
    return {3'(idx), port_we, port_a, port_ds, port_d, port_we ? 16'h0 : cli_q};
  endfunction

  task automatic wait_done(input int budget, output int cyc, output int idx, output bit to);
    cyc = 0; idx = -1; to = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
    end while (cli_done == '0 && cyc < budget);
    if (cli_done == '0) to = 1'b1;
    else for (int k = NCLI - 1; k >= 0; k--) if (cli_done[k]) idx = k;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b, required 1", busy); end
    n_cmp++; if (cli_done !== '0) begin n_err++; $display("FAIL reset_done: got %b, required 0", cli_done); end
    n_cmp++; if (cli_q !== '0) begin n_err++; $display("FAIL reset_q: got %h, required 0", cli_q); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b, required 0", timeout_err); end
    n_cmp++; if ({port_we, port_a, port_ds, port_d} !== '0) begin
      n_err++; $display("FAIL reset_port: got %h, required 0", {port_we, port_a, port_ds, port_d});
    end
    reset = 1'b0;
    exp_rr = NCLI - 1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sync_to_idle: busy %b, required 0", busy); end
  endtask

  task automatic test_single_write();
    int c, idx, extra; bit to, f; exp_t e;
    ack_delay = 3;
    drive(1, 1'b1, 23'h000123, 2'b11, 16'hBEEF);
    @(negedge clk);
    cli_a[1*AW +: AW] = 23'h7FFFFF;
    cli_d[1*DW +: DW] = 16'hDEAD;
    wait_done(40, c, idx, to);
    n_cmp++; if (to || c + 1 != 6) begin n_err++; $display("FAIL write_latency: got %0d cycles (timeout %0d), required 6", c + 1, to); end
    e = pop_exp(1, f);
    n_cmp++; if (!f || observe(idx) !== e) begin n_err++; $display("FAIL write_cmd: got %h, required %h", observe(idx), e); end
    exp_preq = ~exp_preq; exp_rr = 1;
    n_cmp++; if (port_req !== exp_preq) begin n_err++; $display("FAIL write_toggle: got %b, required %b", port_req, exp_preq); end
    cli_req[1] = 1'b0;
    extra = 0;
    repeat (5) begin @(negedge clk); if (cli_done != '0) extra++; end
    n_cmp++; if (extra != 0) begin n_err++; $display("FAIL write_single_pulse: got %0d extra pulses, required 0", extra); end
  endtask

  task automatic test_read();
    int c, idx; bit to, f; exp_t e;
    mem[23'h400010] = 16'h5A5A;
    drive(2, 1'b0, 23'h400010, 2'b01, 16'h0000);
    wait_done(40, c, idx, to);
    e = pop_exp(2, f);
    n_cmp++; if (to || !f || observe(idx) !== e) begin n_err++; $display("FAIL read_cmd: got %h, required %h", observe(idx), e); end
    n_cmp++; if (cli_q !== 16'h5A5A) begin n_err++; $display("FAIL read_q: got %h, required 5a5a", cli_q); end
    exp_preq = ~exp_preq; exp_rr = 2;
    cli_req[2] = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (cli_q !== 16'h5A5A) begin n_err++; $display("FAIL read_q_hold: got %h, required 5a5a", cli_q); end
  endtask

  task automatic test_arbitration();
    int order[$]; int p, c, idx, n0, want; bit to, f; exp_t e;
    ack_delay = 1;
    order = {0, 0, 0};
    p = exp_rr;
    for (int k = 0; k < 6; k++) begin p = (p >= NCLI - 1) ? 1 : p + 1; order.push_back(p); end
    n0 = 0;
    drive(0, 1'b1, 23'h010000, 2'b11, 16'h0A00);
    drive(1, 1'b0, 23'h020001, 2'b10, 16'h0000);
    drive(2, 1'b1, 23'h030002, 2'b01, 16'h2C00);
    for (int g = 0; g < 9; g++) begin
      wait_done(30, c, idx, to);
      n_cmp++; if (to) begin n_err++; $display("FAIL arb_timeout: grant %0d never completed", g); break; end
      want = order.pop_front();
      n_cmp++; if (idx != want) begin n_err++; $display("FAIL arb_order: grant %0d got client %0d, required %0d", g, idx, want); end
      e = pop_exp(idx, f);
      n_cmp++; if (!f || observe(idx) !== e) begin n_err++; $display("FAIL arb_cmd: got %h, required %h", observe(idx), e); end
      exp_preq = ~exp_preq;
      if (idx != 0) exp_rr = idx;
      n_cmp++; if (port_req !== exp_preq) begin n_err++; $display("FAIL arb_toggle: got %b, required %b", port_req, exp_preq); end
      if (g == 8) cli_req = '0;
      else if (idx == 0) begin
        n0++;
        if (n0 < 3) drive(0, 1'b0, 23'(23'h010100 + g), 2'b11, 16'h0000);
        else cli_req[0] = 1'b0;
      end else drive(idx, g[0], 23'(idx * 23'h040000 + g), 2'b11, 16'(16'hD000 + g * 16'h11));
    end
    cli_req = '0;
    exp_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_hold_low();
    int c, idx, bad, want; bit to, f; exp_t e;
    hold_low = 1'b1;
    drive(1, 1'b1, 23'h055501, 2'b10, 16'h1111);
    drive(2, 1'b0, 23'h066602, 2'b01, 16'h0000);
    bad = 0;
    repeat (12) begin @(negedge clk); if (busy || cli_done != '0) bad++; end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL hold_block: got %0d active cycles, required 0", bad); end
    drive(0, 1'b1, 23'h000777, 2'b11, 16'h7777);
    wait_done(30, c, idx, to);
    e = pop_exp(0, f);
    n_cmp++; if (to || idx != 0 || !f || observe(idx) !== e) begin n_err++; $display("FAIL hold_client0: got %h, required %h", observe(idx), e); end
    exp_preq = ~exp_preq;
    cli_req[0] = 1'b0;
    bad = 0;
    repeat (6) begin @(negedge clk); if (busy) bad++; end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL hold_after0: got %0d busy cycles, required 0", bad); end
    hold_low = 1'b0;
    for (int g = 0; g < 2; g++) begin
      want = (exp_rr >= NCLI - 1) ? 1 : exp_rr + 1;
      wait_done(30, c, idx, to);
      n_cmp++; if (to || idx != want) begin n_err++; $display("FAIL hold_release_order: got %0d, required %0d", idx, want); end
      if (to) break;
      e = pop_exp(idx, f);
      n_cmp++; if (!f || observe(idx) !== e) begin n_err++; $display("FAIL hold_release_cmd: got %h, required %h", observe(idx), e); end
      exp_preq = ~exp_preq; exp_rr = idx;
      cli_req[idx] = 1'b0;
    end
    cli_req = '0;
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_watchdog();
    int c, idx, n; bit to, f; exp_t e;
    ack_delay = 20;
    drive(1, 1'b1, 23'h0000AA, 2'b11, 16'hC0DE);
    n = 0;
    do begin @(negedge clk); n++; end while (port_req == port_ack && n < 10);
    n_cmp++; if (port_req == port_ack) begin n_err++; $display("FAIL wdog_issue: port_req never toggled, required toggle"); end
    repeat (7) @(negedge clk);
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL wdog_early: got %b after 7 WAIT cycles, required 0", timeout_err); end
    @(negedge clk);
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL wdog_set: got %b after 8 WAIT cycles, required 1", timeout_err); end
    wait_done(40, c, idx, to);
    e = pop_exp(1, f);
    n_cmp++; if (to || !f || observe(idx) !== e) begin n_err++; $display("FAIL wdog_complete: got %h, required %h", observe(idx), e); end
    exp_preq = ~exp_preq; exp_rr = 1;
    cli_req[1] = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL wdog_sticky: got %b, required 1", timeout_err); end
    ack_delay = 3;
  endtask

  task automatic test_reset_mid_wait();
    int c, idx, bad, n; bit to, f; exp_t e;
    ack_hold = 1'b1;
    ack_delay = 1;
    drive(0, 1'b0, 23'h012345, 2'b11, 16'h0000);
    exp_q.delete();
    repeat (3) @(negedge clk);
    exp_preq = ~exp_preq;
    n_cmp++; if (port_req !== exp_preq || port_ack === port_req) begin
      n_err++; $display("FAIL midwait_setup: req %b ack %b, required req %b pending", port_req, port_ack, exp_preq);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cli_req = '0;
    exp_rr = NCLI - 1;
    bad = 0;
    repeat (5) begin @(negedge clk); if (!busy || cli_done != '0) bad++; end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL midwait_sync: got %0d bad cycles, required 0", bad); end
    ack_hold = 1'b0;
    n = 0; bad = 0;
    do begin @(negedge clk); n++; if (cli_done != '0) bad++; end while (busy && n < 10);
    n_cmp++; if (busy || bad != 0) begin n_err++; $display("FAIL midwait_drain: busy %b dones %0d, required 0 0", busy, bad); end
    n_cmp++; if (cli_q !== '0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL midwait_clear: q %h err %b, required 0 0", cli_q, timeout_err); end
    drive(2, 1'b0, 23'h0ABCDE, 2'b11, 16'h0000);
    wait_done(30, c, idx, to);
    e = pop_exp(2, f);
    n_cmp++; if (to || !f || observe(idx) !== e) begin n_err++; $display("FAIL midwait_next: got %h, required %h", observe(idx), e); end
    exp_preq = ~exp_preq; exp_rr = 2;
    n_cmp++; if (port_req !== exp_preq) begin n_err++; $display("FAIL midwait_toggle: got %b, required %b", port_req, exp_preq); end
    cli_req[2] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int c, idx; bit to, f; exp_t e;
    ack_delay = 1;
    drive(1, 1'b1, 23'h000321, 2'b11, 16'h1234);
    wait_done(30, c, idx, to);
    e = pop_exp(1, f);
    n_cmp++; if (to || !f || observe(idx) !== e) begin n_err++; $display("FAIL b2b_first: got %h, required %h", observe(idx), e); end
    exp_preq = ~exp_preq;
    drive(1, 1'b0, 23'h000654, 2'b10, 16'h0000);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: busy %b after done, required 0", busy); end
    wait_done(30, c, idx, to);
    n_cmp++; if (to || c != 4) begin n_err++; $display("FAIL b2b_gap: got %0d cycles, required 4", c); end
    e = pop_exp(1, f);
    n_cmp++; if (!f || observe(idx) !== e) begin n_err++; $display("FAIL b2b_second: got %h, required %h", observe(idx), e); end
    exp_preq = ~exp_preq;
    n_cmp++; if (port_req !== exp_preq) begin n_err++; $display("FAIL b2b_toggle: got %b, required %b", port_req, exp_preq); end
    cli_req[1] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_arbitration();
    test_hold_low();
    test_watchdog();
    test_reset_mid_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
